// File: rtl/rram_cmd_sequencer.sv
// Host-side PROGRAM/COMPUTE sequencer for rram_core: drives strobes, snapshots ADC codes, streams result beats.
// Optional feature macro: RRAM_SEQ_SUM_EN (registered sum of all snapshot codes on res_sum).
module rram_cmd_sequencer #(
  parameter int NUM_ADCS    = 32,
  parameter int ADC_W       = 4,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BEAT_ADCS   = 8,
  parameter int PULSE_CYC   = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                                    CLK,
  input  logic                                    RESET,
  input  logic                                    cmd_valid,
  output logic                                    cmd_ready,
  input  logic                                    cmd_op,
  input  logic [ADDR_W-1:0]                       cmd_addr,
  input  logic [DATA_W-1:0]                       cmd_wl,
  input  logic [DATA_W-1:0]                       cmd_bl,
  input  logic [3:0]                              cmd_adcsel,
  output logic                                    WR_WL,
  output logic                                    WR_BL,
  output logic                                    WE,
  output logic                                    RE,
  output logic [DATA_W-1:0]                       DATAIN,
  output logic [ADDR_W-1:0]                       ADDR,
  output logic [3:0]                              ADCSEL,
  output logic                                    valid_i,
  output logic                                    ready_i,
  input  logic                                    ready_o,
  input  logic                                    valid_o,
  input  logic [NUM_ADCS*ADC_W-1:0]               ADCout,
  output logic                                    res_valid,
  input  logic                                    res_ready,
  output logic [BEAT_ADCS*ADC_W-1:0]              res_data,
  output logic                                    res_last,
  output logic [ADC_W+$clog2(NUM_ADCS+1)-1:0]     res_sum,
  output logic                                    err_timeout
);
  localparam int NBEATS  = NUM_ADCS / BEAT_ADCS;
  localparam int BEAT_DW = BEAT_ADCS * ADC_W;
  localparam int SUM_W   = ADC_W + $clog2(NUM_ADCS + 1);
  localparam int BEAT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int PC_W    = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam int TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_WL, S_G1, S_BL, S_G2, S_WEP, S_RD, S_WAIT, S_OUT
  } state_t;

  state_t                      state_q, state_d;
  logic                        op_q, op_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [DATA_W-1:0]           wl_q, wl_d, bl_q, bl_d;
  logic [3:0]                  adcsel_q, adcsel_d;
  logic [PC_W-1:0]             pcnt_q, pcnt_d;
  logic [TO_W-1:0]             tcnt_q, tcnt_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic [NUM_ADCS*ADC_W-1:0]   snap_q, snap_d;
  logic                        err_q, err_d;
  logic                        cap;
  logic                        pulse_done;

  assign cmd_ready  = (state_q == S_IDLE) & ready_o & ~RESET;
  assign pulse_done = (pcnt_q == PC_W'(PULSE_CYC - 1));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wl_d     = wl_q;
    bl_d     = bl_q;
    adcsel_d = adcsel_q;
    pcnt_d   = pcnt_q;
    tcnt_d   = tcnt_q;
    beat_d   = beat_q;
    snap_d   = snap_q;
    err_d    = err_q;
    cap      = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_valid && cmd_ready) begin
        op_d     = cmd_op;
        addr_d   = cmd_addr;
        wl_d     = cmd_wl;
        bl_d     = cmd_bl;
        adcsel_d = cmd_adcsel;
        pcnt_d   = '0;
        state_d  = S_WL;
      end
      S_WL:  if (pulse_done) begin pcnt_d = '0; state_d = S_G1; end else pcnt_d = pcnt_q + 1'b1;
      S_G1:  state_d = op_q ? S_RD : S_BL;
      S_BL:  if (pulse_done) begin pcnt_d = '0; state_d = S_G2; end else pcnt_d = pcnt_q + 1'b1;
      S_G2:  state_d = S_WEP;
      S_WEP: if (pulse_done) begin pcnt_d = '0; state_d = S_IDLE; end else pcnt_d = pcnt_q + 1'b1;
      S_RD: begin
        // A result already valid while RE first rises is taken without waiting.
        tcnt_d = '0;
        if (valid_o) cap = 1'b1;
        else         state_d = S_WAIT;
      end
      S_WAIT: begin
        if (valid_o) cap = 1'b1;
        else if (tcnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else tcnt_d = tcnt_q + 1'b1;
      end
      S_OUT: if (res_ready) begin
        if (beat_q == BEAT_W'(NBEATS - 1)) state_d = S_IDLE;
        else                               beat_d  = beat_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (cap) begin
      snap_d  = ADCout;
      beat_d  = '0;
      state_d = S_OUT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      addr_q   <= '0;
      wl_q     <= '0;
      bl_q     <= '0;
      adcsel_q <= '0;
      pcnt_q   <= '0;
      tcnt_q   <= '0;
      beat_q   <= '0;
      snap_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wl_q     <= wl_d;
      bl_q     <= bl_d;
      adcsel_q <= adcsel_d;
      pcnt_q   <= pcnt_d;
      tcnt_q   <= tcnt_d;
      beat_q   <= beat_d;
      snap_q   <= snap_d;
      err_q    <= err_d;
    end
  end

  assign WR_WL       = (state_q == S_WL);
  assign WR_BL       = (state_q == S_BL);
  assign WE          = (state_q == S_WEP);
  assign RE          = (state_q == S_RD) | (state_q == S_WAIT);
  assign ready_i     = (state_q == S_WAIT);
  assign valid_i     = (state_q != S_IDLE) & (state_q != S_OUT);
  assign DATAIN      = WR_WL ? wl_q : (WR_BL ? bl_q : '0);
  assign ADDR        = addr_q;
  assign ADCSEL      = adcsel_q;
  assign res_valid   = (state_q == S_OUT);
  assign res_data    = res_valid ? snap_q[32'(beat_q)*BEAT_DW +: BEAT_DW] : '0;
  assign res_last    = res_valid & (beat_q == BEAT_W'(NBEATS - 1));
  assign err_timeout = err_q;

`ifdef RRAM_SEQ_SUM_EN
  logic [SUM_W-1:0] sum_q, sum_d, adc_sum;

  always_comb begin
    adc_sum = '0;
    for (int k = 0; k < NUM_ADCS; k++) adc_sum = adc_sum + SUM_W'(ADCout[k*ADC_W +: ADC_W]);
  end

  assign sum_d = cap ? adc_sum : sum_q;

  always_ff @(posedge CLK) begin
    if (RESET) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign res_sum = res_valid ? sum_q : '0;
`else
  assign res_sum = '0;
`endif
endmodule

// File: tb/tb_rram_cmd_sequencer.sv
// Bench for rram_cmd_sequencer: schedule-based reference model, directed scenarios, then randomized traffic.
module tb_rram_cmd_sequencer;
  localparam int NUM_ADCS = 32, ADC_W = 4, ADDR_W = 10, DATA_W = 32, BEAT_ADCS = 8;
  localparam int PULSE_CYC = 1, TIMEOUT_CYC = 255;
  localparam int NB = NUM_ADCS / BEAT_ADCS, BDW = BEAT_ADCS * ADC_W;
  localparam int SUM_W = ADC_W + $clog2(NUM_ADCS + 1), AW = NUM_ADCS * ADC_W;
  localparam int P_GAP = 0, P_WL = 1, P_BL = 2, P_WE = 3, P_RD = 4;

  logic CLK = 1'b0, RESET;
  logic cmd_valid, cmd_ready, cmd_op;
  logic [ADDR_W-1:0] cmd_addr, ADDR;
  logic [DATA_W-1:0] cmd_wl, cmd_bl, DATAIN;
  logic [3:0] cmd_adcsel, ADCSEL;
  logic WR_WL, WR_BL, WE, RE, valid_i, ready_i, ready_o, valid_o;
  logic [AW-1:0] ADCout;
  logic res_valid, res_ready, res_last, err_timeout;
  logic [BDW-1:0] res_data;
  logic [SUM_W-1:0] res_sum;

  rram_cmd_sequencer dut (
    .CLK(CLK), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wl(cmd_wl), .cmd_bl(cmd_bl), .cmd_adcsel(cmd_adcsel),
    .WR_WL(WR_WL), .WR_BL(WR_BL), .WE(WE), .RE(RE), .DATAIN(DATAIN), .ADDR(ADDR), .ADCSEL(ADCSEL),
    .valid_i(valid_i), .ready_i(ready_i), .ready_o(ready_o), .valid_o(valid_o), .ADCout(ADCout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .res_sum(res_sum), .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of expected strobe cycles, then wait/result phases.
  int m_phase = 0;
  int m_sched[$];
  int m_wait = 0, m_beat = 0;
  logic [AW-1:0] m_snap = '0;
  logic [SUM_W-1:0] m_sum = '0;
  logic m_err = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wl = '0, m_bl = '0;
  logic [3:0] m_sel = '0;

  logic e_wl, e_bl, e_we, e_re, e_vi, e_ri, e_rv, e_rl, e_crdy;
  logic [DATA_W-1:0] e_data;
  logic [BDW-1:0] e_rd;
  logic [SUM_W-1:0] e_sum;
  int h;

  task automatic model_capture();
    m_snap = ADCout;
    m_sum = '0;
    for (int k = 0; k < NUM_ADCS; k++) m_sum = m_sum + ADCout[k*ADC_W +: ADC_W];
    m_beat = 0;
    m_phase = 3;
  endtask

  always @(negedge CLK) begin
    e_wl = 0; e_bl = 0; e_we = 0; e_re = 0; e_vi = 0; e_ri = 0; e_rv = 0; e_rl = 0; e_crdy = 0;
    e_data = '0; e_rd = '0; e_sum = '0;
    case (m_phase)
      0: e_crdy = ready_o & ~RESET;
      1: begin
        e_vi = 1;
        case (m_sched[0])
          P_WL: begin e_wl = 1; e_data = m_wl; end
          P_BL: begin e_bl = 1; e_data = m_bl; end
          P_WE: e_we = 1;
          P_RD: e_re = 1;
          default: ;
        endcase
      end
      2: begin e_re = 1; e_ri = 1; e_vi = 1; end
      3: begin
        e_rv = 1;
        e_rd = m_snap[m_beat*BDW +: BDW];
        e_rl = (m_beat == NB - 1);
`ifdef RRAM_SEQ_SUM_EN
        e_sum = m_sum;
`endif
      end
      default: ;
    endcase
    if (chk_en) begin
      chk("WR_WL", WR_WL, e_wl);        chk("WR_BL", WR_BL, e_bl);
      chk("WE", WE, e_we);              chk("RE", RE, e_re);
      chk("valid_i", valid_i, e_vi);    chk("ready_i", ready_i, e_ri);
      chk("DATAIN", DATAIN, e_data);    chk("ADDR", ADDR, m_addr);
      chk("ADCSEL", ADCSEL, m_sel);     chk("cmd_ready", cmd_ready, e_crdy);
      chk("res_valid", res_valid, e_rv); chk("res_data", res_data, e_rd);
      chk("res_last", res_last, e_rl);  chk("res_sum", res_sum, e_sum);
      chk("err_timeout", err_timeout, m_err);
    end
    if (RESET) begin
      m_phase = 0; m_sched.delete(); m_addr = '0; m_wl = '0; m_bl = '0; m_sel = '0;
      m_err = 0; m_snap = '0; m_beat = 0; m_sum = '0;
    end else begin
      case (m_phase)
        0: if (cmd_valid && ready_o) begin
          m_addr = cmd_addr; m_wl = cmd_wl; m_bl = cmd_bl; m_sel = cmd_adcsel;
          repeat (PULSE_CYC) m_sched.push_back(P_WL);
          m_sched.push_back(P_GAP);
          if (cmd_op) m_sched.push_back(P_RD);
          else begin
            repeat (PULSE_CYC) m_sched.push_back(P_BL);
            m_sched.push_back(P_GAP);
            repeat (PULSE_CYC) m_sched.push_back(P_WE);
          end
          m_phase = 1;
        end
        1: begin
          h = m_sched.pop_front();
          if (h == P_RD && valid_o) model_capture();
          else if (m_sched.size() == 0) begin
            if (h == P_RD) begin m_phase = 2; m_wait = 0; end
            else m_phase = 0;
          end
        end
        2: begin
          m_wait++;
          if (valid_o) model_capture();
          else if (m_wait == TIMEOUT_CYC) begin m_err = 1; m_phase = 0; end
        end
        3: if (res_ready) begin
          if (m_beat == NB - 1) m_phase = 0;
          else m_beat++;
        end
        default: ;
      endcase
    end
  end

  // Core emulation: 0 = never answers, 1 = ADC k = k%16 on the 10th RE cycle, 2 = random.
  int core_mode = 0;
  int re_cnt = 0;
  initial begin
    valid_o = 0; ADCout = '0;
    forever begin
      @(posedge CLK); #2;
      re_cnt = RE ? re_cnt + 1 : 0;
      case (core_mode)
        1: begin
          valid_o = RE && re_cnt >= 10;
          for (int k = 0; k < NUM_ADCS; k++) ADCout[k*ADC_W +: ADC_W] = ADC_W'(k % 16);
        end
        2: begin
          valid_o = RE ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
          for (int w = 0; w < AW / 32; w++) ADCout[w*32 +: 32] = $urandom;
        end
        default: valid_o = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic issue(input logic op, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wl,
                       input logic [DATA_W-1:0] bl, input logic [3:0] sel);
    int n = 0;
    cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_wl = wl; cmd_bl = bl; cmd_adcsel = sel;
    while (!cmd_ready && n < 50) begin step(); n++; end
    chk("issue_accept", cmd_ready, 1'b1);
    step();
    cmd_valid = 0;
  endtask

  logic [BDW-1:0] got[$];
  logic got_last[$];
  logic [SUM_W-1:0] got_sum;

  task automatic collect(input bit toggle);
    int cyc = 0;
    bit done = 0;
    got.delete(); got_last.delete();
    while (!done && cyc < 600) begin
      @(negedge CLK);
      if (res_valid && res_ready) begin
        got.push_back(res_data); got_last.push_back(res_last); got_sum = res_sum;
        if (res_last) done = 1;
      end
      step();
      if (toggle) res_ready = ~res_ready;
      cyc++;
    end
    chk("collect_done", done, 1'b1);
  endtask

  initial begin
    logic [2:0] exp_s [1:6] = '{3'b100, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000};
    logic [2:0] st [1:6];
    logic [DATA_W-1:0] dt [1:6];
    logic cr6;
    int re_n, cyc;
    bit rv_seen;
    RESET = 1; cmd_valid = 0; cmd_op = 0; cmd_addr = '0; cmd_wl = '0; cmd_bl = '0; cmd_adcsel = '0;
    ready_o = 0; res_ready = 0;
    step();
    chk_en = 1;
    repeat (4) step();
    @(negedge CLK);
    chk("reset_strobes", {WR_WL, WR_BL, WE, RE, valid_i, ready_i, res_valid, res_last, err_timeout, cmd_ready}, '0);
    chk("reset_buses", {DATAIN, ADDR, ADCSEL, res_data, res_sum}, '0);
    step(); RESET = 0; ready_o = 1;
    @(negedge CLK); chk("ready_after_reset", cmd_ready, 1'b1);
    step(); ready_o = 0;
    @(negedge CLK); chk("ready_follows_ready_o", cmd_ready, 1'b0);
    step(); ready_o = 1;

    // PROGRAM: strobe timeline relative to the accept cycle.
    issue(1'b0, 10'h000, 32'h1, 32'hFFFF, 4'h0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      st[i] = {WR_WL, WR_BL, WE}; dt[i] = DATAIN;
      if (i == 6) cr6 = cmd_ready;
      step();
    end
    for (int i = 1; i <= 6; i++) chk($sformatf("prog_strobe_c%0d", i), st[i], exp_s[i]);
    chk("prog_wl_data", dt[1], 32'h1);
    chk("prog_bl_data", dt[3], 32'hFFFF);
    chk("prog_ready_n6", cr6, 1'b1);

    // COMPUTE with a well-behaved core.
    core_mode = 1; res_ready = 1;
    issue(1'b1, 10'h155, 32'hA5A5_0F0F, 32'h0, 4'h3);
    @(negedge CLK); chk("compute_addr", ADDR, 10'h155); chk("compute_adcsel", ADCSEL, 4'h3);
    collect(0);
    chk("beats_n", got.size(), 4);
    chk("beat0", got[0], 32'h76543210);
    chk("beat1", got[1], 32'hFEDCBA98);
    chk("beat3", got[3], 32'hFEDCBA98);
    chk("last_beat0", got_last[0], 1'b0);
    chk("last_beat3", got_last[3], 1'b1);
`ifdef RRAM_SEQ_SUM_EN
    chk("sum", got_sum, 10'd240);
`endif

    // COMPUTE with back-pressure toggling.
    res_ready = 0;
    issue(1'b1, 10'h2A, 32'h3, 32'h0, 4'h1);
    collect(1);
    chk("toggle_beats_n", got.size(), 4);
    chk("toggle_beat0", got[0], 32'h76543210);
    chk("toggle_beat1", got[1], 32'hFEDCBA98);
    chk("toggle_beat2", got[2], 32'h76543210);
    chk("toggle_beat3", got[3], 32'hFEDCBA98);

    // COMPUTE with a silent core: timeout.
    core_mode = 0; res_ready = 1;
    step();
    issue(1'b1, 10'h3FF, 32'hFFFF_FFFF, 32'h0, 4'hF);
    re_n = 0; cyc = 0; rv_seen = 0;
    while (!err_timeout && cyc < 400) begin
      @(negedge CLK);
      if (RE) re_n++;
      if (res_valid) rv_seen = 1;
      step(); cyc++;
    end
    @(negedge CLK);
    chk("timeout_re_cycles", re_n, 256);
    chk("timeout_err", err_timeout, 1'b1);
    chk("timeout_re_low", RE, 1'b0);
    chk("timeout_no_result", rv_seen, 1'b0);
    step();

    // RESET while waiting for the core.
    issue(1'b1, 10'h10, 32'h5, 32'h0, 4'h2);
    repeat (20) step();
    @(negedge CLK); chk("wait_re", RE, 1'b1); chk("wait_ready_i", ready_i, 1'b1);
    step(); RESET = 1;
    step(); RESET = 0;
    @(negedge CLK);
    chk("rst_re", RE, 1'b0); chk("rst_valid_i", valid_i, 1'b0);
    chk("rst_err", err_timeout, 1'b0); chk("rst_cmd_ready", cmd_ready, 1'b1);

    // Randomized traffic; the model checks every cycle.
    core_mode = 2;
    for (int c = 0; c < 4000; c++) begin
      step();
      RESET      = ($urandom_range(0, 499) == 0);
      cmd_valid  = $urandom_range(0, 1);
      cmd_op     = $urandom_range(0, 1);
      cmd_addr   = ADDR_W'($urandom);
      cmd_wl     = $urandom;
      cmd_bl     = $urandom;
      cmd_adcsel = 4'($urandom);
      ready_o    = ($urandom_range(0, 4) != 0);
      res_ready  = ($urandom_range(0, 4) < 3);
    end
    step(); RESET = 0;
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
